// File: rtl/brainhack_pkg.sv
// Shared opcode and FSM state encodings for the brainhack_io core.
package brainhack_pkg;

   typedef enum logic [2:0] {
      OP_OUT   = 3'b000,
      OP_IN    = 3'b001,
      OP_INC   = 3'b010,
      OP_DEC   = 3'b011,
      OP_RIGHT = 3'b100,
      OP_LEFT  = 3'b101,
      OP_LOOP  = 3'b110,
      OP_END   = 3'b111
   } opcode_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_SKIP  = 3'd3,
      ST_OUT   = 3'd4,
      ST_IN    = 3'd5,
      ST_HALT  = 3'd6,
      ST_ERROR = 3'd7
   } state_t;

endpackage

// File: rtl/inc_dec.sv
// Modular increment/decrement unit shared by tape data and pointer paths.
module inc_dec #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic         dec,
   output logic [W-1:0] y
);

   localparam logic [W-1:0] ONE = W'(1);

   assign y = dec ? (a - ONE) : (a + ONE);

endmodule

// File: rtl/brainhack_io.sv
// Brainfuck-style interpreter core with external program, tape and loop-stack memories.
//
// state | meaning
// IDLE  | waiting for i_start after reset
// FETCH | halt on PC==PRG_LEN, otherwise latch IR
// EXEC  | execute IR
// SKIP  | scan forward past a loop whose entry cell was zero
// OUT   | present tape cell until sink accepts
// IN    | wait for an input byte and store it
// HALT  | program ran off the end; sticky
// ERROR | loop stack over/underflow; sticky
module brainhack_io
   import brainhack_pkg::*;
#(
   parameter int TAPE_DATA_W  = 8,
   parameter int TAPE_ADDR_W  = 8,
   parameter int PRG_ADDR_W   = 8,
   parameter int STACK_ADDR_W = 4,
   parameter int PRG_LEN      = 256
) (
   input  logic                    i_clock,
   input  logic                    i_reset_n,
   input  logic                    i_start,
   input  logic [2:0]              i_prgmem_data,
   input  logic [TAPE_DATA_W-1:0]  i_tape_data,
   input  logic [PRG_ADDR_W-1:0]   i_stack_data,
   input  logic                    i_in_valid,
   input  logic [TAPE_DATA_W-1:0]  i_in_data,
   input  logic                    i_out_ready,
   output logic [PRG_ADDR_W-1:0]   o_prgmem_addr,
   output logic                    o_tape_we,
   output logic [TAPE_ADDR_W-1:0]  o_tape_addr,
   output logic [TAPE_DATA_W-1:0]  o_tape_data,
   output logic                    o_stack_we,
   output logic [STACK_ADDR_W-1:0] o_stack_addr,
   output logic [PRG_ADDR_W-1:0]   o_stack_data,
   output logic                    o_in_ready,
   output logic                    o_out_valid,
   output logic [TAPE_DATA_W-1:0]  o_out_data,
   output logic                    o_busy,
   output logic                    o_halted,
   output logic                    o_error
);

   localparam int PCW = PRG_ADDR_W + 1;
   localparam int SPW = STACK_ADDR_W + 1;

   localparam logic [PCW-1:0] PC_ONE  = PCW'(1);
   localparam logic [PCW-1:0] PC_END  = PCW'(PRG_LEN);
   localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
   localparam logic [SPW-1:0] SP_FULL = SPW'(1) << STACK_ADDR_W;

   state_t                  state, state_nxt;
   opcode_t                 ir, ir_nxt;
   opcode_t                 skip_op;
   logic [PCW-1:0]          pc, pc_nxt, pc_inc, depth, depth_nxt;
   logic [SPW-1:0]          sp, sp_nxt, sp_dec;
   logic [TAPE_ADDR_W-1:0]  ptr, ptr_nxt, ptr_upd;
   logic [TAPE_DATA_W-1:0]  cell_upd;
   logic                    cell_zero;
   logic                    push;

   inc_dec #(.W(TAPE_DATA_W)) u_cell (.a(i_tape_data), .dec(ir == OP_DEC),  .y(cell_upd));
   inc_dec #(.W(TAPE_ADDR_W)) u_ptr  (.a(ptr),         .dec(ir == OP_LEFT), .y(ptr_upd));

   assign pc_inc    = pc + PC_ONE;
   assign sp_dec    = sp - SP_ONE;
   assign cell_zero = (i_tape_data == '0);
   assign skip_op   = opcode_t'(i_prgmem_data);

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) state <= ST_IDLE;
      else            state <= state_nxt;
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         pc    <= '0;
         sp    <= '0;
         ptr   <= '0;
         ir    <= OP_OUT;
         depth <= '0;
      end else begin
         pc    <= pc_nxt;
         sp    <= sp_nxt;
         ptr   <= ptr_nxt;
         ir    <= ir_nxt;
         depth <= depth_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      sp_nxt      = sp;
      ptr_nxt     = ptr;
      ir_nxt      = ir;
      depth_nxt   = depth;
      push        = 1'b0;
      o_tape_we   = 1'b0;
      o_tape_data = cell_upd;
      o_stack_we  = 1'b0;
      o_in_ready  = 1'b0;
      o_out_valid = 1'b0;
      case (state)
         ST_IDLE, ST_HALT, ST_ERROR: begin
            if (i_start) begin
               pc_nxt    = '0;
               sp_nxt    = '0;
               ptr_nxt   = '0;
               state_nxt = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (pc == PC_END) begin
               state_nxt = ST_HALT;
            end else begin
               ir_nxt    = opcode_t'(i_prgmem_data);
               state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_nxt = ST_FETCH;
            pc_nxt    = pc_inc;
            case (ir)
               OP_INC, OP_DEC:    o_tape_we = 1'b1;
               OP_RIGHT, OP_LEFT: ptr_nxt = ptr_upd;
               OP_LOOP: begin
                  if (cell_zero) begin
                     depth_nxt = PC_ONE;
                     state_nxt = ST_SKIP;
                  end else if (sp == SP_FULL) begin
                     pc_nxt    = pc;
                     state_nxt = ST_ERROR;
                  end else begin
                     push       = 1'b1;
                     o_stack_we = 1'b1;
                     sp_nxt     = sp + SP_ONE;
                  end
               end
               OP_END: begin
                  if (sp == '0) begin
                     pc_nxt    = pc;
                     state_nxt = ST_ERROR;
                  end else if (!cell_zero) begin
                     pc_nxt = {1'b0, i_stack_data} + PC_ONE;
                  end else begin
                     sp_nxt = sp_dec;
                  end
               end
               OP_OUT: begin
                  pc_nxt    = pc;
                  state_nxt = ST_OUT;
               end
               OP_IN: begin
                  pc_nxt    = pc;
                  state_nxt = ST_IN;
               end
               default: ;
            endcase
         end
         ST_SKIP: begin
            if (pc == PC_END) begin
               state_nxt = ST_HALT;
            end else begin
               pc_nxt = pc_inc;
               if (skip_op == OP_LOOP) begin
                  depth_nxt = depth + PC_ONE;
               end else if (skip_op == OP_END) begin
                  depth_nxt = depth - PC_ONE;
                  if (depth == PC_ONE) state_nxt = ST_FETCH;
               end
            end
         end
         ST_OUT: begin
            o_out_valid = 1'b1;
            if (i_out_ready) begin
               pc_nxt    = pc_inc;
               state_nxt = ST_FETCH;
            end
         end
         ST_IN: begin
            o_in_ready = 1'b1;
            if (i_in_valid) begin
               o_tape_we   = 1'b1;
               o_tape_data = i_in_data;
               pc_nxt      = pc_inc;
               state_nxt   = ST_FETCH;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Push addresses the free slot; every other access looks at the top entry.
   assign o_stack_addr  = push ? sp[STACK_ADDR_W-1:0] : sp_dec[STACK_ADDR_W-1:0];
   assign o_stack_data  = pc[PRG_ADDR_W-1:0];
   assign o_prgmem_addr = pc[PRG_ADDR_W-1:0];
   assign o_tape_addr   = ptr;
   assign o_out_data    = i_tape_data;
   assign o_busy        = (state == ST_FETCH) || (state == ST_EXEC) || (state == ST_SKIP) ||
                          (state == ST_OUT)   || (state == ST_IN);
   assign o_halted      = (state == ST_HALT);
   assign o_error       = (state == ST_ERROR);

endmodule
